// File: rtl/mdu_unit_if.sv
// Execute-stage request/result bundle between the pipeline and the multiply/divide unit.
// The master drives a request (start/op/operands); the slave returns busy and the HI/LO registers.
interface mdu_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, a, b, input  busy, hi, lo);
    modport slave  (input  start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/mdu_unit.sv
// Multiply/divide unit beside the ALU: owns HI/LO, computes the result at acceptance and
// holds it in a pending register until the modelled latency expires.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      reset,
    mdu_unit_if.slave bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } opT;

    typedef enum logic {IDLE, BUSY} stateT;

    stateT            state;
    logic [CNT_W-1:0] count;
    logic             busyQ;
    logic [31:0]      hiQ, loQ;
    logic [31:0]      pendHi, pendLo;
    logic             pendValid;

    logic        mulSigned, divSigned, negA, negB;
    logic [63:0] extA, extB, mulProd;
    logic [31:0] absA, absB, divisor, quotMag, remMag, divQuot, divRem;

    // NOTE: every signal written here gets a value on every pass, so no latch can be inferred.
    always_comb begin
        mulSigned = (opT'(bus.op) == OP_MULT);
        extA      = mulSigned ? {{32{bus.a[31]}}, bus.a} : {32'b0, bus.a};
        extB      = mulSigned ? {{32{bus.b[31]}}, bus.b} : {32'b0, bus.b};
        mulProd   = extA * extB;

        // Signed division on magnitudes: quotient truncates toward zero, remainder follows dividend.
        divSigned = (opT'(bus.op) == OP_DIV);
        negA      = divSigned & bus.a[31];
        negB      = divSigned & bus.b[31];
        absA      = negA ? -bus.a : bus.a;
        absB      = negB ? -bus.b : bus.b;
        divisor   = (absB == 32'd0) ? 32'd1 : absB;
        quotMag   = absA / divisor;
        remMag    = absA % divisor;
        divQuot   = (negA ^ negB) ? -quotMag : quotMag;
        divRem    = negA ? -remMag : remMag;
    end

    // NOTE: all state lives in one clocked block using <=, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= '0;
            busyQ     <= 1'b0;
            hiQ       <= '0;
            loQ       <= '0;
            pendHi    <= '0;
            pendLo    <= '0;
            pendValid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        case (opT'(bus.op))
                            OP_MULT, OP_MULTU: begin
                                pendHi    <= mulProd[63:32];
                                pendLo    <= mulProd[31:0];
                                pendValid <= 1'b1;
                                count     <= CNT_W'(MULT_CYCLES);
                                busyQ     <= 1'b1;
                                state     <= BUSY;
                            end
                            OP_DIV, OP_DIVU: begin
                                pendHi    <= divRem;
                                pendLo    <= divQuot;
                                pendValid <= (bus.b != 32'd0);
                                count     <= CNT_W'(DIV_CYCLES);
                                busyQ     <= 1'b1;
                                state     <= BUSY;
                            end
                            OP_MTHI: hiQ <= bus.a;
                            OP_MTLO: loQ <= bus.a;
                            default: ;
                        endcase
                    end
                end
                BUSY: begin
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        state <= IDLE;
                        busyQ <= 1'b0;
                        if (pendValid) begin
                            hiQ <= pendHi;
                            loQ <= pendLo;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busyQ;
    assign bus.hi   = hiQ;
    assign bus.lo   = loQ;

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: the driver pushes expected HI/LO and timing per request,
// a negedge monitor checks busy every cycle and pops results when they are due.
module tb_mdu_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mdu_unit_if bus();

    mdu_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        int unsigned accept;
        int unsigned due;
        logic [31:0] hi;
        logic [31:0] lo;
        string       tag;
    } expT;

    expT         sb[$];
    int unsigned cyc = 0;
    int unsigned lastDue = 0;
    int          total = 0;
    int          bad = 0;
    logic [31:0] mHi = '0;
    logic [31:0] mLo = '0;
    bit          monOn = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    // Architectural reference: plain 64-bit arithmetic on the operands.
    function automatic logic [63:0] refOp(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
        longint sa, sbv, q, r;
        logic [63:0] res;
        res = {hi, lo};
        case (op)
            3'd1: begin
                sa  = longint'($signed(a));
                sbv = longint'($signed(b));
                res = sa * sbv;
            end
            3'd2: res = {32'b0, a} * {32'b0, b};
            3'd3: if (b != 0) begin
                sa  = longint'($signed(a));
                sbv = longint'($signed(b));
                q   = sa / sbv;
                r   = sa % sbv;
                res = {r[31:0], q[31:0]};
            end
            3'd4: if (b != 0) res = {a % b, a / b};
            3'd5: res = {a, lo};
            3'd6: res = {hi, a};
            default: ;
        endcase
        return res;
    endfunction

    initial begin
        bit  expBusy;
        expT e;
        forever begin
            @(negedge clk);
            if (monOn) begin
                expBusy = (sb.size() > 0) && (sb[0].accept <= cyc) && (cyc < sb[0].due);
                check("busy", {31'b0, bus.busy}, {31'b0, expBusy});
                while (sb.size() > 0 && sb[0].due == cyc) begin
                    e = sb.pop_front();
                    check({e.tag, " hi"}, bus.hi, e.hi);
                    check({e.tag, " lo"}, bus.lo, e.lo);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitIdle();
        while (cyc < lastDue) tick();
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        expT         e;
        logic [63:0] r;
        int          n;
        waitIdle();
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        n = (op == 3'd1 || op == 3'd2) ? MULT_N : (op == 3'd3 || op == 3'd4) ? DIV_N : 0;
        if (op >= 3'd1 && op <= 3'd6) begin
            r        = refOp(op, a, b, mHi, mLo);
            mHi      = r[63:32];
            mLo      = r[31:0];
            e.accept = cyc + 1;
            e.due    = cyc + 1 + n;
            e.hi     = mHi;
            e.lo     = mLo;
            e.tag    = tag;
            sb.push_back(e);
            lastDue  = e.due;
        end
        tick();
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    // Request presented while the unit is busy; must leave no trace.
    task automatic poke(input logic [2:0] op, input logic [31:0] a);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = $urandom;
        tick();
        bus.start = 1'b0;
        bus.op    = 3'd0;
    endtask

    task automatic probe(input string tag);
        expT e;
        e.accept = cyc;
        e.due    = cyc;
        e.hi     = mHi;
        e.lo     = mLo;
        e.tag    = tag;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 100));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int guard;
        logic [2:0] op;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.a     = '0;
        bus.b     = '0;

        reset = 1'b0;
        tick();
        tick();
        reset   = 1'b1;
        monOn   = 1'b1;
        lastDue = cyc;
        probe("reset");

        issue(3'd1, 32'hFFFF_FFFE, 32'd3, "mult neg");
        issue(3'd2, 32'hFFFF_FFFE, 32'd3, "multu");
        issue(3'd3, 32'hFFFF_FFF9, 32'd2, "div neg");
        issue(3'd4, 32'd7, 32'd2, "divu");
        issue(3'd5, 32'h11, 32'd0, "mthi");
        issue(3'd6, 32'h22, 32'd0, "mtlo");
        issue(3'd3, 32'd5, 32'd0, "div by zero");
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div ovf");
        issue(3'd5, 32'hDEAD_BEEF, 32'd0, "mthi beef");
        issue(3'd1, 32'h1234, 32'h5678, "mult vs mtlo");
        poke(3'd6, 32'h1234_5678);
        issue(3'd7, 32'hAAAA_AAAA, 32'd1, "reserved");
        issue(3'd0, 32'hBBBB_BBBB, 32'd1, "none");
        waitIdle();
        probe("after none");

        issue(3'd1, 32'd7, 32'd9, "mult aborted");
        tick();
        tick();
        reset = 1'b0;
        tick();
        sb.delete();
        mHi     = '0;
        mLo     = '0;
        lastDue = cyc;
        probe("abort");
        reset = 1'b1;
        repeat (8) tick();
        probe("no late commit");
        issue(3'd1, 32'd4, 32'd5, "mult 4x5");

        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            issue(op, pickOperand(), pickOperand(), $sformatf("rand%0d op%0d", i, op));
            if (cyc < lastDue && $urandom_range(0, 2) == 0)
                poke(3'($urandom_range(1, 6)), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                waitIdle();
                repeat ($urandom_range(0, 2)) tick();
            end
        end

        guard = 0;
        while (sb.size() > 0 && guard < 200) begin
            tick();
            guard++;
        end
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d results never due, head %s", sb.size(), sb[0].tag);
        end
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit in the Execute stage, beside the ALU.
- Takes forwarded rs/rt operands from E and holds the HI/LO architectural registers.
- Models multi-cycle latency with a busy flag; the hazard unit uses it to stall D.
- E-stage mfhi/mflo read hi/lo combinationally; the values travel down the EX/MEM register with ALU results.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1)

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-low reset (0 = reset)
- start  input  1  request strobe from E; qualified by op, ignored when op=NONE/reserved
- op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved
- a  input  32  operand A (forwarded rs)
- b  input  32  operand B (forwarded rt)
- busy  output  1  operation in flight
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset (reset=0 at edge): state=IDLE, counter=0, busy=0, hi=0, lo=0, pending result cleared. Reset overrides start. Reset mid-operation aborts the operation with no commit.
- FSM states: IDLE, BUSY.
- IDLE, start=1, op MULT/MULTU:
  - Compute 64-bit product: signed for MULT, unsigned for MULTU.
  - Latch product into pending {phi,plo}; counter=MULT_CYCLES; go to BUSY.
- IDLE, start=1, op DIV/DIVU:
  - pending plo=quotient, phi=remainder; counter=DIV_CYCLES; go to BUSY.
  - Signed division truncates toward zero; remainder takes the dividend's sign.
  - a=0x80000000, b=0xFFFFFFFF (DIV): plo=0x80000000, phi=0.
  - b=0: no commit at all. HI/LO stay unchanged, but busy still asserts for DIV_CYCLES.
- IDLE, start=1, op MTHI/MTLO: hi (or lo) <= a at that edge. No busy cycle; new value visible next cycle.
- busy is registered. It is 1 for exactly N consecutive cycles starting the cycle after the accepting edge (N = MULT_CYCLES or DIV_CYCLES).
- BUSY: counter decrements each edge.
  - On the edge where counter goes 1->0: {hi,lo} <= pending (unless div-by-zero), state=IDLE, busy=0.
  - Result is readable in the first cycle busy=0.
- hi/lo keep their old values throughout BUSY, and are never partially updated.
- start while busy=1 (any op): ignored with no effect. The hazard unit stalls D on (busy | start) when D holds an MDU instruction. The unit relies on that stall and does not queue requests.
- NONE/reserved op with start=1: no effect.
- a/b are sampled only at the accepting edge; later changes do not affect the result.
- Back-to-back: a new start in the first cycle with busy=0 is accepted. hi/lo commit of the old op and acceptance of the new one are on different edges.

Test Plan:
- Reset held 0 for 2 cycles then released -> hi=0, lo=0, busy=0.
- MULT a=0xFFFFFFFE(-2), b=3 -> busy=1 for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=-7 (0xFFFFFFF9), b=2 -> after 10 busy cycles lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1). DIVU a=7, b=2 -> lo=3, hi=1.
- DIV with b=0, prior hi=0x11, lo=0x22 -> busy 10 cycles, hi/lo remain 0x11/0x22. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0xDEADBEEF in IDLE -> hi=0xDEADBEEF next cycle, busy never 1. MTLO issued while busy -> ignored, lo gets only the pending result.
- MULT started, reset=0 at cycle 3 of busy -> busy=0, hi=lo=0, no later commit. Restart MULT 4*5 -> lo=20, hi=0.
